// File: rtl/fp_round_unit_pkg.sv
// Shared types and constants for the FP rounding stage.
//   float_t      : IEEE-754 single {sign, exponent, mantissa}
//   round_mode_t : RISC-V rounding modes (DYN resolved before this unit)
//   fflags_t     : per-op exception flags {nv, dz, of, uf, nx}
package fp_round_unit_pkg;

    localparam int unsigned FLEN        = 32;
    localparam int unsigned EXP_W       = 8;
    localparam int unsigned MANT_W      = 23;
    localparam int unsigned GRS_W       = 3;
    localparam int unsigned RM_W        = 3;
    localparam int unsigned FFLAGS_W    = 5;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [MANT_W-1:0] mantissa;
    } float_t;

    localparam float_t CANO_NAN     = 32'h7FC0_0000;
    localparam float_t P_INFTY      = 32'h7F80_0000;
    localparam float_t N_INFTY      = 32'hFF80_0000;
    localparam float_t MAX_FINITE_P = 32'h7F7F_FFFF;
    localparam float_t MAX_FINITE_N = 32'hFF7F_FFFF;

    typedef enum logic [RM_W-1:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } round_mode_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Stage-1 register payload
    typedef struct packed {
        float_t           operand;
        logic             inc;
        logic             nx;
        logic [RM_W-1:0]  mode;
        logic             invalid;
        logic             divbyzero;
        logic             overflow;
        logic             underflow;
    } s1_payload_t;

    // Encodings above RMM are reserved (DYN must never reach this unit)
    function automatic logic is_reserved_mode(input logic [RM_W-1:0] m);
        return m > 3'b100;
    endfunction

endpackage

// File: rtl/fp_round_unit_decide.sv
// Combinational round-up decision.
//   sign_i : operand sign     lsb_i  : mantissa LSB
//   grs_i  : guard/round/sticky      mode_i : rounding mode
//   inc_c  : add one ULP to the magnitude
module fp_round_decide
    import fp_round_unit_pkg::*;
(
    input  logic            sign_i,
    input  logic            lsb_i,
    input  logic [GRS_W-1:0] grs_i,
    input  logic [RM_W-1:0] mode_i,
    output logic            inc_c
);

    logic nx_c;

    always_comb begin
        inc_c = 1'b0;
        nx_c  = |grs_i;
        case (mode_i)
            RNE:     inc_c = grs_i[2] & (grs_i[1] | grs_i[0] | lsb_i);
            RTZ:     inc_c = 1'b0;
            RDN:     inc_c = sign_i & nx_c;
            RUP:     inc_c = !sign_i & nx_c;
            RMM:     inc_c = grs_i[2];
            default: inc_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_unit.sv
// Final FP pipeline stage: rounding, overflow resolution, fflags generation
// and the accrued fflags register. Two register stages, valid/ready.
//   clk_i, rst_i (sync, active-high)
//   valid_i/ready_o, operand_i, grs_i, round_mode_i, *_i hints : input beat
//   valid_o/ready_i, result_o, fflags_o                        : output beat
//   clear_fflags_i, accrued_fflags_o                           : fcsr flags
module fp_round_unit
    import fp_round_unit_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned FLEN_P      = FLEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [FLEN_P-1:0]   operand_i,
    input  logic [GRS_W-1:0]    grs_i,
    input  logic [RM_W-1:0]     round_mode_i,
    input  logic                invalid_i,
    input  logic                divbyzero_i,
    input  logic                overflow_i,
    input  logic                underflow_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [FLEN_P-1:0]   result_o,
    output logic [FFLAGS_W-1:0] fflags_o,
    input  logic                clear_fflags_i,
    output logic [FFLAGS_W-1:0] accrued_fflags_o
);

    if (PIPE_STAGES != 2 || FLEN_P != FLEN) begin : g_cfg_check
        $error("fp_round_unit: only PIPE_STAGES=2 and FLEN=32 are supported");
    end

    float_t      op_in;
    logic        inc_c;
    logic        adv1_c, adv2_c, out_xfer_c;
    logic        s1_valid_d, s1_valid_q;
    s1_payload_t s1_d, s1_q;
    logic        s2_valid_d, s2_valid_q;
    float_t      result_d, result_q;
    fflags_t     fflags_d, fflags_q;
    fflags_t     acc_d, acc_q;
    logic [EXP_W+MANT_W-1:0] sum_c;
    logic        exp_max_c, ovf_c, to_inf_c;
    float_t      res_c;
    fflags_t     flags_c;

    assign op_in = float_t'(operand_i);

    fp_round_decide u_decide (
        .sign_i (op_in.sign),
        .lsb_i  (op_in.mantissa[0]),
        .grs_i  (grs_i),
        .mode_i (round_mode_i),
        .inc_c  (inc_c)
    );

    // Stage 2 datapath: apply increment and resolve special cases
    always_comb begin
        sum_c     = {s1_q.operand.exponent, s1_q.operand.mantissa}
                    + (EXP_W+MANT_W)'(s1_q.inc);
        exp_max_c = (s1_q.operand.exponent == 8'hFF);
        ovf_c     = s1_q.overflow | (sum_c[EXP_W+MANT_W-1:MANT_W] == 8'hFF);
        to_inf_c  = (s1_q.mode == RNE) || (s1_q.mode == RMM)
                    || ((s1_q.mode == RUP) && !s1_q.operand.sign)
                    || ((s1_q.mode == RDN) && s1_q.operand.sign);
        res_c      = {s1_q.operand.sign, sum_c};
        flags_c.nv = s1_q.invalid;
        flags_c.dz = s1_q.divbyzero;
        flags_c.of = 1'b0;
        flags_c.uf = s1_q.underflow & s1_q.nx;
        flags_c.nx = s1_q.nx;
        if (is_reserved_mode(s1_q.mode)) begin
            res_c      = CANO_NAN;
            flags_c    = '0;
            flags_c.nv = 1'b1;
        end else if (exp_max_c && (s1_q.operand.mantissa != '0)) begin
            res_c      = CANO_NAN;
            flags_c.of = 1'b0;
            flags_c.uf = 1'b0;
            flags_c.nx = 1'b0;
        end else if (exp_max_c) begin
            // Infinity is exact: passes through untouched
            res_c      = s1_q.operand;
            flags_c.uf = 1'b0;
            flags_c.nx = 1'b0;
        end else if (ovf_c) begin
            flags_c.of = 1'b1;
            flags_c.nx = 1'b1;
            if (to_inf_c) begin
                res_c = s1_q.operand.sign ? N_INFTY : P_INFTY;
            end else begin
                res_c = s1_q.operand.sign ? MAX_FINITE_N : MAX_FINITE_P;
            end
        end
    end

    // Handshake, stage advance and accrued flags
    always_comb begin
        adv2_c     = !s2_valid_q | ready_i;
        adv1_c     = !s1_valid_q | adv2_c;
        out_xfer_c = s2_valid_q & ready_i;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        fflags_d   = fflags_q;
        acc_d      = acc_q;
        if (adv1_c) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_d.operand   = op_in;
                s1_d.inc       = inc_c;
                s1_d.nx        = |grs_i;
                s1_d.mode      = round_mode_i;
                s1_d.invalid   = invalid_i;
                s1_d.divbyzero = divbyzero_i;
                s1_d.overflow  = overflow_i;
                s1_d.underflow = underflow_i;
            end
        end
        if (adv2_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res_c;
                fflags_d = flags_c;
            end
        end
        // Clear discards history but keeps flags delivered this same cycle
        if (clear_fflags_i) begin
            acc_d = out_xfer_c ? fflags_q : '0;
        end else if (out_xfer_c) begin
            acc_d = acc_q | fflags_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            fflags_q   <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            fflags_q   <= fflags_d;
            acc_q      <= acc_d;
        end
    end

    assign ready_o          = adv1_c;
    assign valid_o          = s2_valid_q;
    assign result_o         = result_q;
    assign fflags_o         = fflags_q;
    assign accrued_fflags_o = acc_q;

endmodule

// File: tb/tb_fp_round_unit.sv
// Scoreboard bench for fp_round_unit: driver pushes expected results at the
// input handshake, a negedge monitor pops and compares on each output transfer.
module tb_fp_round_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_i;
    logic [2:0]  grs_i;
    logic [2:0]  round_mode_i;
    logic        invalid_i, divbyzero_i, overflow_i, underflow_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;
    logic        clear_fflags_i;
    logic [4:0]  accrued_fflags_o;

    fp_round_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .operand_i        (operand_i),
        .grs_i            (grs_i),
        .round_mode_i     (round_mode_i),
        .invalid_i        (invalid_i),
        .divbyzero_i      (divbyzero_i),
        .overflow_i       (overflow_i),
        .underflow_i      (underflow_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .result_o         (result_o),
        .fflags_o         (fflags_o),
        .clear_fflags_i   (clear_fflags_i),
        .accrued_fflags_o (accrued_fflags_o)
    );

    always #5 clk_i = ~clk_i;

    int cnt = 0;
    always @(posedge clk_i) cnt <= cnt + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          hs;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares on every output transfer and checks hold under stall
    logic        held = 1'b0;
    logic [31:0] held_res;
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("valid_hold", 64'(valid_o), 64'd1);
                check("result_stable", 64'(result_o), 64'(held_res));
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %08h expected none", result_o);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(result_o), 64'(e.res));
                    check("fflags", 64'(fflags_o), 64'(e.flg));
                    if (e.chk_lat) check("latency", 64'(cnt - e.hs), 64'd2);
                end
            end
            held     = valid_o && !ready_i;
            held_res = result_o;
        end
    end

    // hints = {invalid, divbyzero, overflow, underflow}
    task automatic send(input logic [31:0] op, input logic [2:0] grs, input logic [2:0] mode,
                        input logic [3:0] hints, input logic [31:0] er, input logic [4:0] ef,
                        input bit lat);
        exp_t e;
        bit   done;
        @(posedge clk_i); #1;
        valid_i      = 1'b1;
        operand_i    = op;
        grs_i        = grs;
        round_mode_i = mode;
        {invalid_i, divbyzero_i, overflow_i, underflow_i} = hints;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk_i);
            if (ready_o) begin
                e.res = er; e.flg = ef; e.hs = cnt; e.chk_lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) check("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk_i);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_fflags_i = 1'b0;
        operand_i = '0; grs_i = '0; round_mode_i = '0;
        invalid_i = 1'b0; divbyzero_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_result_o", 64'(result_o), 64'd0);
        check("rst_fflags_o", 64'(fflags_o), 64'd0);
        check("rst_accrued", 64'(accrued_fflags_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);

        // RNE ties, back-to-back
        send(32'h3F80_0001, 3'b100, 3'd0, 4'b0000, 32'h3F80_0002, 5'b00001, 1'b1);
        send(32'h3F80_0000, 3'b100, 3'd0, 4'b0000, 32'h3F80_0000, 5'b00001, 1'b1);
        // Carry into exponent
        send(32'h3FFF_FFFF, 3'b110, 3'd3, 4'b0000, 32'h4000_0000, 5'b00001, 1'b1);
        send(32'h3FFF_FFFF, 3'b110, 3'd1, 4'b0000, 32'h3FFF_FFFF, 5'b00001, 1'b1);
        // Overflow flagged upstream
        send(32'h7F7F_FFFF, 3'b111, 3'd0, 4'b0010, 32'h7F80_0000, 5'b00101, 1'b1);
        send(32'h7F7F_FFFF, 3'b111, 3'd1, 4'b0010, 32'h7F7F_FFFF, 5'b00101, 1'b1);
        send(32'hFF7F_FFFF, 3'b111, 3'd3, 4'b0010, 32'hFF7F_FFFF, 5'b00101, 1'b1);
        // Overflow produced by the rounding add itself
        send(32'h7F7F_FFFF, 3'b100, 3'd3, 4'b0000, 32'h7F80_0000, 5'b00101, 1'b1);
        // NaN, infinity, underflow, subnormal->normal, RDN, RMM, reserved
        send(32'h7FC1_2345, 3'b000, 3'd0, 4'b1000, 32'h7FC0_0000, 5'b10000, 1'b1);
        send(32'hFF80_0000, 3'b111, 3'd1, 4'b0000, 32'hFF80_0000, 5'b00000, 1'b1);
        send(32'h0000_0001, 3'b100, 3'd0, 4'b0001, 32'h0000_0002, 5'b00011, 1'b1);
        send(32'h007F_FFFF, 3'b100, 3'd0, 4'b0000, 32'h0080_0000, 5'b00001, 1'b1);
        send(32'h8000_0001, 3'b001, 3'd2, 4'b0000, 32'h8000_0002, 5'b00001, 1'b1);
        send(32'h3F80_0000, 3'b100, 3'd4, 4'b0000, 32'h3F80_0001, 5'b00001, 1'b1);
        send(32'h3F80_0000, 3'b000, 3'd5, 4'b0000, 32'h7FC0_0000, 5'b10000, 1'b1);
        idle();
        drain();

        // Backpressure: four beats while the output side stalls
        fork
            begin
                send(32'h3F80_0000, 3'b000, 3'd0, 4'b0000, 32'h3F80_0000, 5'b00000, 1'b0);
                send(32'h3F80_0001, 3'b011, 3'd3, 4'b0000, 32'h3F80_0002, 5'b00001, 1'b0);
                send(32'h4000_0000, 3'b000, 3'd0, 4'b0000, 32'h4000_0000, 5'b00000, 1'b0);
                send(32'hBF80_0000, 3'b010, 3'd2, 4'b0000, 32'hBF80_0001, 5'b00001, 1'b0);
                idle();
            end
            begin
                @(posedge clk_i); #1;
                ready_i = 1'b0;
                repeat (3) @(negedge clk_i);
                check("bp_ready_o_low", 64'(ready_o), 64'd0);
                repeat (3) @(posedge clk_i);
                #1 ready_i = 1'b1;
            end
        join
        drain();

        // Accrued flags
        @(posedge clk_i); #1 clear_fflags_i = 1'b1;
        @(posedge clk_i); #1 clear_fflags_i = 1'b0;
        @(negedge clk_i);
        check("acc_cleared", 64'(accrued_fflags_o), 64'd0);
        send(32'h3F80_0000, 3'b001, 3'd1, 4'b0000, 32'h3F80_0000, 5'b00001, 1'b1);
        send(32'h3F80_0000, 3'b000, 3'd0, 4'b0100, 32'h3F80_0000, 5'b01000, 1'b1);
        idle();
        drain();
        @(negedge clk_i);
        check("acc_or", 64'(accrued_fflags_o), 64'h09);
        send(32'h3F80_0000, 3'b000, 3'd0, 4'b1000, 32'h3F80_0000, 5'b10000, 1'b1);
        idle();
        @(posedge clk_i); #1 clear_fflags_i = 1'b1;
        @(posedge clk_i); #1 clear_fflags_i = 1'b0;
        @(negedge clk_i);
        check("acc_clear_with_xfer", 64'(accrued_fflags_o), 64'h10);
        drain();

        // Reset with two beats in flight
        @(posedge clk_i); #1 ready_i = 1'b0;
        send(32'h3F80_0001, 3'b100, 3'd0, 4'b0000, 32'h3F80_0002, 5'b00001, 1'b0);
        send(32'h3F80_0003, 3'b100, 3'd0, 4'b0000, 32'h3F80_0004, 5'b00001, 1'b0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        rst_i   = 1'b1;
        sb.delete();
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_valid_o", 64'(valid_o), 64'd0);
        check("post_rst_accrued", 64'(accrued_fflags_o), 64'd0);
        check("post_rst_ready_o", 64'(ready_o), 64'd1);
        repeat (8) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/fp_round_unit.md
Name: fp_round_unit

Overview:
- Final pipeline stage of the FP datapath; consumes the `to_round_unit` result of the arithmetic units (mag/add/mul/div) together with guard/round/sticky bits and exception hints.
- Applies the RISC-V rounding mode, resolves overflow and underflow into the IEEE-754 single result, and produces per-op fflags.
- Maintains the accrued fflags register that feeds fcsr.
- Two-stage pipeline with valid/ready handshake.

Parameters:
- PIPE_STAGES, 2, fixed latency in cycles from input handshake to valid_o (only 2 supported).
- FLEN, 32, float width; must equal $bits(float_t).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: one clock, synchronous, active-high.
- valid_i  in  1  input beat valid.
- ready_o  out  1  unit can accept an input beat.
- operand_i  in  32  float_t unrounded result: sign, exponent[7:0], mantissa[22:0].
- grs_i  in  3  guard, round, sticky bits below mantissa LSB.
- round_mode_i  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101/110/111 are reserved. DYN is resolved upstream.
- invalid_i  in  1  NV hint from the upstream unit.
- divbyzero_i  in  1  DZ hint.
- overflow_i  in  1  upstream exponent overflow.
- underflow_i  in  1  upstream tiny result.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  32  rounded float_t.
- fflags_o  out  5  per-op flags {NV,DZ,OF,UF,NX}, qualified by valid_o.
- clear_fflags_i  in  1  clear the accrued flags (CSR write).
- accrued_fflags_o  out  5  sticky OR of all delivered fflags.

Behaviour:
Reset:
- While rst_i=1 at a clock edge: both stage valid bits go to 0, result_o=0, fflags_o=0, accrued_fflags_o=0.
- In-flight beats are dropped with no flag update.
- ready_o=1 in the first cycle after reset.

Handshake and pipeline:
- Input transfer occurs when valid_i&ready_o. Output transfer occurs when valid_o&ready_i.
- adv2 = !s2_valid | ready_i.
- adv1 = !s1_valid | adv2.
- ready_o = adv1.
- Stalled stages hold their data unchanged. valid_o must not drop without an output transfer.
- Throughput is 1 beat per cycle when ready_i=1. Latency is exactly 2 cycles.

Stage 1 (register inputs, compute increment; mant_lsb = operand_i.mantissa[0], nx = |grs_i):
- RNE: inc = G&(R|S|mant_lsb).
- RTZ: inc = 0.
- RDN: inc = sign&nx.
- RUP: inc = !sign&nx.
- RMM: inc = G.

Stage 2 (apply increment):
- {exp,mant} = {exponent,mantissa} + inc, as a 31-bit add. A mantissa carry increments the exponent, and a subnormal rounds up to a normal naturally.
- NaN input (exp=FF, mant!=0): output CANO_NAN. NX=0; NV = invalid_i.
- Infinity input: pass through unchanged. NX=0, OF=0.
- Overflow (overflow_i=1, or the 31-bit add yields exp=FF):
  - OF=1, NX=1.
  - Result is infinity for RNE/RMM, and for RUP+/RDN-.
  - Result is MAX_FINITE with the input sign (0x7F7FFFFF magnitude) for RTZ, RUP-, RDN+.
- Underflow: UF = underflow_i & nx.
- NX = nx | OF. NV = invalid_i. DZ = divbyzero_i.
- Reserved round mode: result = CANO_NAN, NV=1, other flags 0.

Accrued flags:
- On an output transfer: acc <= acc | fflags_o.
- clear_fflags_i=1: acc <= (transfer ? fflags_o : 0). Clear wins over old content, but a coincident transfer's flags are kept.

Decomposition:
- Modules_pkg: float_t (existing), CANO_NAN, P_INFTY, N_INFTY (existing); add MAX_FINITE_P=0x7F7FFFFF, MAX_FINITE_N=0xFF7FFFFF.
- Instruction_pkg: round_mode_t enum (RNE,RTZ,RDN,RUP,RMM,DYN) and fflags_t packed struct {nv,dz,of,uf,nx}.
- One natural sub-module, fp_round_decide: purely combinational inc computation from sign, lsb, grs and mode. It is instantiated in stage 1 and reused by future FCVT rounding.

Test Plan:
- RNE tie to even, in consecutive beats with ready_i=1:
  - operand 0x3F800001, grs=100 -> result 0x3F800002, NX=1.
  - operand 0x3F800000, grs=100 -> 0x3F800000, NX=1.
  - Both results appear on valid_o exactly 2 cycles after their input handshakes.
- Carry into exponent: operand 0x3FFFFFFF, grs=110, RUP -> result 0x40000000, fflags=00001. Same operand with RTZ -> 0x3FFFFFFF, fflags=00001.
- Overflow, operand 0x7F7FFFFF, grs=111:
  - RNE -> 0x7F800000, fflags=00101.
  - RTZ -> 0x7F7FFFFF, fflags=00101.
  - Negative operand 0xFF7FFFFF, RUP -> 0xFF7FFFFF.
- Backpressure: 4 back-to-back inputs with ready_i held low from cycle 2 to cycle 6.
  - ready_o deasserts once both stages are full.
  - No beat is lost or duplicated, and output order is preserved.
  - result_o is stable while valid_o&!ready_i.
- Accrued flags: deliver beats with flags 00001 then 00100 -> accrued=00101. Then clear_fflags_i in the same cycle as a beat delivering 10000 -> accrued=10000.
- Reserved mode and reset: round_mode=101 -> result 0x7FC00000, NV=1. Assert rst_i with 2 beats in flight -> next cycle valid_o=0, accrued=0, ready_o=1, and no stale beat emerges afterwards.
